// File: rtl/or_reduce_stream.sv
// -----------------------------------------------------------------------------
// or_reduce_stream
//
// Collects a packet of words from a valid/ready stream and returns the bitwise
// OR of every word together with the number of words in the packet. The word
// count saturates at its all-ones value. The OR keeps folding in words after
// the count has saturated.
//
// The control is a three-state machine:
//   IDLE  no packet open
//   ACC   packet open, accumulating
//   HOLD  result presented, waiting for downstream
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream word valid
//   in_ready   block accepts a word this cycle (registered)
//   in_data    word to OR into the running result
//   in_last    final word of the packet (looked at only on an accepted word)
//   out_valid  result available (registered, high exactly in HOLD)
//   out_ready  downstream accepts the result
//   out_data   OR of all words of the packet
//   out_count  number of words in the packet, saturating
// -----------------------------------------------------------------------------
module or_reduce_stream #(
  parameter int width       = 48,
  parameter int count_width = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [count_width-1:0] out_count
);

  generate
    if (width < 1 || width > 48) begin : g_bad_width
      $error("or_reduce_stream: width must be in 1..48");
    end
    if (count_width < 1 || count_width > 16) begin : g_bad_count_width
      $error("or_reduce_stream: count_width must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [count_width-1:0] CNT_ONE = count_width'(1);
  localparam logic [count_width-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [width-1:0]       acc;
  logic [count_width-1:0] cnt;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [count_width-1:0] sat_inc(
    input logic [count_width-1:0] c
  );
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // in_ready and out_valid are registered. in_ready is 0 during reset and
  // only rises on the first edge after reset is released, so acceptance is
  // gated by the registered in_ready and never by the state alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_valid && in_ready) begin
            if (state == IDLE) begin
              acc <= in_data;
              cnt <= CNT_ONE;
            end else begin
              acc <= acc | in_data;
              cnt <= sat_inc(cnt);
            end
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state     <= ACC;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          // No word is taken in the consume cycle; in_ready returns next cycle.
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = acc;
  assign out_count = cnt;

endmodule

// File: tb/tb_or_reduce_stream.sv
module tb_or_reduce_stream;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Narrow instance: width 8, 2-bit counter (saturates at 3)
  logic       v8, l8, or8, ir8, ov8;
  logic [7:0] d8, od8;
  logic [1:0] oc8;

  // Wide instance for randomized traffic
  logic        v48, l48, or48, ir48, ov48;
  logic [47:0] d48, od48;
  logic [7:0]  oc48;

  or_reduce_stream #(.width(8), .count_width(2)) u8 (
    .clock(clock), .reset(reset),
    .in_valid(v8), .in_ready(ir8), .in_data(d8), .in_last(l8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_count(oc8)
  );

  or_reduce_stream #(.width(48), .count_width(8)) u48 (
    .clock(clock), .reset(reset),
    .in_valid(v48), .in_ready(ir48), .in_data(d48), .in_last(l48),
    .out_valid(ov48), .out_ready(or48), .out_data(od48), .out_count(oc48)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic e_ov, input logic e_ir,
                      input logic [7:0] e_d, input logic [1:0] e_c);
    chk({nm, ".out_valid"}, 64'(ov8), 64'(e_ov));
    chk({nm, ".in_ready"},  64'(ir8), 64'(e_ir));
    chk({nm, ".out_data"},  64'(od8), 64'(e_d));
    chk({nm, ".out_count"}, 64'(oc8), 64'(e_c));
  endtask

  // One cycle on the narrow instance: drive before the edge, sample after it.
  task automatic cyc8(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    @(negedge clock);
    v8 = v; d8 = d; l8 = l; or8 = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       ordy;
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_d;
    logic [1:0] e_c;
  } vec_t;

  vec_t tbl[12];

  localparam int NPKT = 200;
  logic [47:0] exp_d_q[$];
  int          exp_c_q[$];
  logic [47:0] pkt[$];
  logic [47:0] w, orv;
  int          idx, pk_sent, pk_recv, len;

  initial begin
    v8 = 0; d8 = '0; l8 = 0; or8 = 0;
    v48 = 0; d48 = '0; l48 = 0; or48 = 0;

    // Expected values, cycle by cycle, written out by hand
    // three-word packet -> 0x91, count 3, out_valid one cycle
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 2'd1};
    tbl[1]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd2};
    tbl[2]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'h91, 2'd3};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h91, 2'd3};
    // single-word packet
    tbl[4]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd1};
    // five-word packet with a 2-bit counter: saturates at 3
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'd1};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'd2};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'd3};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'd3};
    tbl[10] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 2'd3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'd3};

    // Asynchronous reset: outputs clear before any clock edge
    #1 reset = 1'b1;
    #1;
    chk8("reset_async", 1'b0, 1'b0, 8'h00, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    chk8("reset_held", 1'b0, 1'b0, 8'h00, 2'd0);
    chk("reset_ir48", 64'(ir48), 64'd0);
    release_reset();
    chk8("after_reset", 1'b0, 1'b1, 8'h00, 2'd0);

    for (int i = 0; i < 12; i++) begin
      cyc8(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      chk8($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_d, tbl[i].e_c);
    end

    // Back-pressure in HOLD while upstream keeps offering words
    cyc8(1'b1, 8'h3C, 1'b1, 1'b0);
    chk8("bp_enter", 1'b1, 1'b0, 8'h3C, 2'd1);
    for (int i = 0; i < 5; i++) begin
      cyc8(1'b1, 8'hFF, 1'b0, 1'b0);
      chk8($sformatf("bp_hold%0d", i), 1'b1, 1'b0, 8'h3C, 2'd1);
    end
    cyc8(1'b1, 8'h55, 1'b1, 1'b1);
    chk8("bp_consume", 1'b0, 1'b1, 8'h3C, 2'd1);
    cyc8(1'b1, 8'h55, 1'b1, 1'b1);
    chk8("bp_next", 1'b1, 1'b0, 8'h55, 2'd1);
    cyc8(1'b0, 8'h00, 1'b0, 1'b1);
    chk8("bp_done", 1'b0, 1'b1, 8'h55, 2'd1);

    // Reset while a result is pending
    cyc8(1'b1, 8'h33, 1'b1, 1'b0);
    chk8("hold_pre_rst", 1'b1, 1'b0, 8'h33, 2'd1);
    #2 reset = 1'b1;
    #1;
    chk8("hold_rst", 1'b0, 1'b0, 8'h00, 2'd0);
    v8 = 0; or8 = 0;
    release_reset();
    chk8("hold_rst_rel", 1'b0, 1'b1, 8'h00, 2'd0);

    // Reset in the middle of an open packet
    cyc8(1'b1, 8'h0F, 1'b0, 1'b1);
    cyc8(1'b1, 8'hF0, 1'b0, 1'b1);
    chk8("mid_pre_rst", 1'b0, 1'b1, 8'hFF, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk8("mid_rst", 1'b0, 1'b0, 8'h00, 2'd0);
    v8 = 0;
    release_reset();
    chk8("mid_rst_rel", 1'b0, 1'b1, 8'h00, 2'd0);
    cyc8(1'b1, 8'h02, 1'b1, 1'b1);
    chk8("post_rst_pkt", 1'b1, 1'b0, 8'h02, 2'd1);
    cyc8(1'b0, 8'h00, 1'b0, 1'b1);
    chk8("post_rst_done", 1'b0, 1'b1, 8'h02, 2'd1);

    // Randomized packets on the wide instance against a packet-level model
    idx = 0; pk_sent = 0; pk_recv = 0;
    for (int c = 0; c < 20000 && pk_recv < NPKT; c++) begin
      @(negedge clock);
      if (idx == pkt.size() && pk_sent < NPKT) begin
        len = $urandom_range(1, 20);
        pkt.delete();
        orv = '0;
        for (int k = 0; k < len; k++) begin
          w = 48'({$urandom(), $urandom()});
          if ($urandom_range(0, 3) == 0) w = w & 48'h0000_0000_00FF;
          pkt.push_back(w);
          orv = orv | w;
        end
        exp_d_q.push_back(orv);
        exp_c_q.push_back(len > 255 ? 255 : len);
        idx = 0;
        pk_sent++;
      end
      if (idx < pkt.size() && $urandom_range(0, 3) != 0) begin
        v48 = 1'b1;
        d48 = pkt[idx];
        l48 = (idx == pkt.size() - 1);
      end else begin
        v48 = 1'b0;
        d48 = 48'({$urandom(), $urandom()});
        l48 = 1'($urandom_range(0, 1));
      end
      or48 = ($urandom_range(0, 2) != 0);
      #1;
      if (v48 && ir48) idx++;
      if (ov48 && or48) begin
        if (exp_d_q.size() == 0) begin
          chk("rand_unexpected", 64'd1, 64'd0);
        end else begin
          chk($sformatf("rand_data%0d", pk_recv), 64'(od48), 64'(exp_d_q[0]));
          chk($sformatf("rand_cnt%0d", pk_recv), 64'(oc48), 64'(exp_c_q[0]));
          void'(exp_d_q.pop_front());
          void'(exp_c_q.pop_front());
        end
        pk_recv++;
      end
    end
    chk("rand_received", 64'(pk_recv), 64'(NPKT));
    chk("rand_leftover", 64'(exp_d_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or_reduce_stream.md
OR_REDUCE_STREAM -- requirements
Module: or_reduce_stream

Interface
REQ-001 Parameter width, default 48, data word width; legal range 1..48; out-of-range SHALL raise an elaboration-time $error.
REQ-002 Parameter count_width, default 8, width of the per-packet word counter; legal range 1..16.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  width  word to OR into the running result.
REQ-008 in_last  input  1  marks the final word of a packet; sampled only on an accepted word.
REQ-009 out_valid  output  1  reduced result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  width  bitwise OR of all words in the packet.
REQ-012 out_count  output  count_width  number of words in the packet, saturating.

Function
REQ-013 Transfer rules: an input word SHALL be accepted when in_valid and in_ready are both 1 at a rising edge; a result SHALL be consumed when out_valid and out_ready are both 1.
REQ-014 State machine SHALL have three states: IDLE (no packet open), ACC (packet open), HOLD (result pending).
REQ-015 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD, and 0 while reset is asserted.
REQ-016 out_valid SHALL be 1 exactly in HOLD.
REQ-017 In IDLE, an accepted word SHALL load acc=in_data and cnt=1; next state is HOLD if in_last=1, else ACC.
REQ-018 In ACC, an accepted word SHALL update acc=acc|in_data and cnt=cnt+1; next state is HOLD if in_last=1, else ACC.
REQ-019 cnt SHALL saturate at 2^count_width-1; acc SHALL keep ORing words past saturation.
REQ-020 If in_valid=0 in IDLE or ACC, state, acc and cnt SHALL hold.
REQ-021 In HOLD, out_data SHALL equal acc and out_count SHALL equal cnt, both stable until consumed.
REQ-022 In HOLD with out_ready=1, the next state SHALL be IDLE; out_ready=0 SHALL hold HOLD indefinitely.
REQ-023 Latency: out_valid SHALL rise on the edge that accepts the in_last word, making the result visible the following cycle; a single-word packet therefore has a latency of 1 cycle.
REQ-024 Throughput: after a result is consumed, in_ready SHALL be 1 in the next cycle (one bubble per packet); no new input word SHALL be accepted in the cycle the result is consumed.
REQ-025 Outside HOLD, out_data and out_count SHALL show acc and cnt; consumers SHALL ignore them.
REQ-026 The OR datapath SHALL be purely bitwise with no sign or zero extension, since both operands are width bits.

Reset
REQ-027 While reset is asserted: state=IDLE, acc=0, cnt=0, out_valid=0, in_ready=0, out_data=0, out_count=0, all immediately and without waiting for a clock edge.
REQ-028 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending result, with no output transfer.
REQ-029 On the first rising edge after reset deasserts, the block SHALL be in IDLE with in_ready=1.

Verification
REQ-030 width=8: send words 0x01,0x10,0x80 (last on 0x80) with out_ready=1 -> one result, out_data=0x91, out_count=3, out_valid high for 1 cycle.
REQ-031 Single word 0xA5 with in_last=1 -> out_valid the next cycle, out_data=0xA5, out_count=1; in_ready=0 during that cycle.
REQ-032 out_ready held 0 for 5 cycles in HOLD while in_valid=1 -> out_data and out_count stable, in_ready=0, no input accepted; release -> consumed, in_ready=1 the next cycle.
REQ-033 count_width=2: send a 5-word packet of 0x00 then 0x04 -> out_count=3 (saturated), out_data=0x04.
REQ-034 Assert reset asynchronously after 2 words of an open packet -> out_valid=0 and in_ready=0 at once; the next packet 0x02 (last) -> out_data=0x02, out_count=1.
REQ-035 width=48, random packets of 1..20 words with random in_valid/out_ready gaps -> every result matches the reference-model OR and count, with no lost or duplicated packets.
